segre_mem_arbiter: RTL

SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

---
 rtl/segre_mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/segre_mem_arbiter.sv
`timescale 1ns/1ps
// Shared memory-port arbiter between the IF (fetch) and MEM stages.
// Latency: request seen in IDLE at edge N drives strobes from cycle N+1; ready is combinational on mem_ready_i.
// Backpressure: requesters hold req until their ready; one IDLE bubble separates transactions.

package segre_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
endpackage

module segre_mem_arbiter
  import segre_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE    = 32,
  parameter int LINE_BYTES   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // IF stage
  input  logic                      if_req_i,
  input  logic [ADDR_SIZE-1:0]      if_addr_i,
  output logic                      if_ready_o,
  // MEM stage
  input  logic                      mem_req_i,
  input  logic                      mem_wr_i,
  input  logic [ADDR_SIZE-1:0]      mem_addr_i,
  input  memop_data_type_e          mem_data_type_i,
  input  logic [LINE_BYTES*8-1:0]   mem_wr_data_i,
  output logic                      mem_ready_o,
  // memory port
  output logic [ADDR_SIZE-1:0]      addr_o,
  output logic                      rd_o,
  output logic                      wr_o,
  output memop_data_type_e          data_type_o,
  output logic [LINE_BYTES*8-1:0]   wr_data_o,
  input  logic                      mem_ready_i,
  output logic                      sel_mem_o,
  output logic                      busy_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic          if_forced;
  logic          grant_mem;

  // IF overrides the default MEM priority once it has been passed over STARVE_LIMIT times
  always_comb begin
    if_forced = if_req_i && (starve_q == STARVE_MAX);
    grant_mem = mem_req_i && !if_forced;
  end

  // Completion is passed straight through to the owner of the port; IDLE swallows stray pulses
  always_comb begin
    if_ready_o  = (state_q == GNT_IF)  && mem_ready_i;
    mem_ready_o = (state_q == GNT_MEM) && mem_ready_i;
    busy_o      = (state_q != IDLE);
  end

  // Arbitration FSM; the memory-port outputs are latched at grant and held for the whole grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      addr_o      <= '0;
      rd_o        <= 1'b0;
      wr_o        <= 1'b0;
      data_type_o <= WORD;
      wr_data_o   <= '0;
      sel_mem_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q     <= GNT_MEM;
            addr_o      <= mem_addr_i;
            rd_o        <= ~mem_wr_i;
            wr_o        <= mem_wr_i;
            data_type_o <= mem_data_type_i;
            wr_data_o   <= mem_wr_data_i;
            sel_mem_o   <= 1'b1;
            // only count grants that actually made IF wait
            if (if_req_i && (starve_q != STARVE_MAX)) begin
              starve_q <= starve_q + SW'(1);
            end
          end else if (if_req_i) begin
            state_q     <= GNT_IF;
            addr_o      <= if_addr_i;
            rd_o        <= 1'b1;
            wr_o        <= 1'b0;
            data_type_o <= WORD;
            wr_data_o   <= '0;
            sel_mem_o   <= 1'b0;
            starve_q    <= '0;
          end
        end
        GNT_IF, GNT_MEM: begin
          // request inputs are deliberately ignored here; only completion ends the grant
          if (mem_ready_i) begin
            state_q   <= IDLE;
            rd_o      <= 1'b0;
            wr_o      <= 1'b0;
            sel_mem_o <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          rd_o      <= 1'b0;
          wr_o      <= 1'b0;
          sel_mem_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
